// File: rtl/write_to_usb.sv
// write_to_usb: drains WORD_COUNT 16-bit results from SDRAM (Wishbone reads) into the FX2 IN FIFO.
// Optional WRITE_TO_USB_ACK_TIMEOUT_EN: 8-bit ack timeout on each read that sets err and aborts.
module write_to_usb #(
  parameter logic [31:0] BASE_ADDR  = 32'd0,
  parameter logic [15:0] WORD_COUNT = 16'd144,
  parameter logic [15:0] PKT_WORDS  = 16'd256,
  parameter logic [1:0]  EP_ADDR    = 2'b10
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        FLAGD,
  output logic [1:0]  FIFOADR,
  output logic        SLWR,
  output logic        SLRD,
  output logic        SLOE,
  output logic        pktend,
  output logic [15:0] fdata_out,
  output logic        fdata_oe,
  input  logic [31:0] data_o,
  input  logic        stall_o,
  input  logic        sdram_ack,
  output logic        stb_i,
  output logic        cyc_i,
  output logic        we_i,
  output logic [3:0]  sel_i,
  output logic [31:0] addr_i
);

  localparam int unsigned IDX_W  = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_CHK, WR_STB, FLUSH, PKTEND, DONE
  } state_t;

  state_t              state, state_d;
  logic [IDX_W-1:0]    idx, idx_d;
  logic [IDX_W-1:0]    pkt_cnt, pkt_d, pkt_inc;
  logic [DATA_W-1:0]   word_d;
  logic                err_d;
  logic                rd_d;
  logic [15:0]         unused_data_hi;

  assign unused_data_hi = data_o[31:16];

`ifdef WRITE_TO_USB_ACK_TIMEOUT_EN
  localparam int unsigned TMO_W = 8;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(255);
  logic [TMO_W-1:0] tmo_cnt, tmo_d;

  // Ack timeout counter: runs only while a read is outstanding.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) tmo_cnt <= '0;
    else        tmo_cnt <= tmo_d;
  end
`endif

  // Next-state and datapath decode.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    pkt_d   = pkt_cnt;
    word_d  = fdata_out;
    err_d   = err;
    pkt_inc = pkt_cnt + IDX_W'(1);
    case (state)
      IDLE: if (start) begin
        state_d = RD_REQ;
        idx_d   = '0;
        pkt_d   = '0;
        err_d   = 1'b0;
      end
      RD_REQ: if (!stall_o) begin
        if (sdram_ack) begin
          word_d  = data_o[DATA_W-1:0];
          state_d = WR_CHK;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (sdram_ack) begin
        word_d  = data_o[DATA_W-1:0];
        state_d = WR_CHK;
      end
      WR_CHK: if (FLAGD) state_d = WR_STB;
      WR_STB: begin
        idx_d   = idx + IDX_W'(1);
        pkt_d   = (pkt_inc == PKT_WORDS) ? '0 : pkt_inc;
        state_d = (idx_d == WORD_COUNT) ? FLUSH : RD_REQ;
      end
      // Full packets are auto-committed by the FX2; only a short tail needs pktend.
      FLUSH: begin
        if (pkt_cnt == '0) state_d = DONE;
        else if (FLAGD)    state_d = PKTEND;
      end
      PKTEND:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef WRITE_TO_USB_ACK_TIMEOUT_EN
    tmo_d = '0;
    if ((state_d == RD_REQ) || (state_d == RD_WAIT)) begin
      if (tmo_cnt == TMO_MAX) begin
        state_d = DONE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_cnt + TMO_W'(1);
      end
    end
`endif
    rd_d = (state_d == RD_REQ) || (state_d == RD_WAIT);
  end

  // State, datapath and registered outputs, all decoded from the next state.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      pkt_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      FIFOADR   <= EP_ADDR;
      SLWR      <= 1'b1;
      SLRD      <= 1'b1;
      SLOE      <= 1'b1;
      pktend    <= 1'b1;
      fdata_out <= '0;
      fdata_oe  <= 1'b0;
      stb_i     <= 1'b0;
      cyc_i     <= 1'b0;
      we_i      <= 1'b0;
      sel_i     <= '0;
      addr_i    <= BASE_ADDR;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      pkt_cnt   <= pkt_d;
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
      err       <= err_d;
      FIFOADR   <= EP_ADDR;
      SLWR      <= (state_d != WR_STB);
      SLRD      <= 1'b1;
      SLOE      <= 1'b1;
      pktend    <= (state_d != PKTEND);
      fdata_out <= word_d;
      fdata_oe  <= (state_d == WR_CHK) || (state_d == WR_STB);
      stb_i     <= (state_d == RD_REQ);
      cyc_i     <= rd_d;
      we_i      <= 1'b0;
      sel_i     <= rd_d ? 4'b0011 : 4'b0000;
      addr_i    <= BASE_ADDR + ADDR_W'(idx_d);
    end
  end

endmodule

// File: tb/tb_write_to_usb.sv
// tb_write_to_usb: scoreboard bench; DUT A (4 words, 256-word packets) and DUT B (8 words,
// 4-word packets, base near 32-bit wrap) share one SDRAM/FX2 environment selected by use_b.
module tb_write_to_usb;

  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFFE;

  logic        CLK = 1'b0;
  logic        rst_n, start, use_b;
  logic        FLAGD, stall_o, sdram_ack;
  logic [31:0] data_o;

  logic busy_a, done_a, err_a, slwr_a, slrd_a, sloe_a, pktend_a, oe_a, stb_a, cyc_a, we_a;
  logic busy_b, done_b, err_b, slwr_b, slrd_b, sloe_b, pktend_b, oe_b, stb_b, cyc_b, we_b;
  logic [1:0]  fifoadr_a, fifoadr_b;
  logic [15:0] fdata_a, fdata_b;
  logic [3:0]  sel_a, sel_b;
  logic [31:0] addr_a, addr_b;

  write_to_usb #(.BASE_ADDR(BASE_A), .WORD_COUNT(16'd4), .PKT_WORDS(16'd256), .EP_ADDR(2'b10)) dut_a (
    .CLK(CLK), .rst_n(rst_n), .start(start & ~use_b), .busy(busy_a), .done(done_a), .err(err_a),
    .FLAGD(FLAGD), .FIFOADR(fifoadr_a), .SLWR(slwr_a), .SLRD(slrd_a), .SLOE(sloe_a),
    .pktend(pktend_a), .fdata_out(fdata_a), .fdata_oe(oe_a), .data_o(data_o), .stall_o(stall_o),
    .sdram_ack(sdram_ack), .stb_i(stb_a), .cyc_i(cyc_a), .we_i(we_a), .sel_i(sel_a), .addr_i(addr_a));

  write_to_usb #(.BASE_ADDR(BASE_B), .WORD_COUNT(16'd8), .PKT_WORDS(16'd4), .EP_ADDR(2'b10)) dut_b (
    .CLK(CLK), .rst_n(rst_n), .start(start & use_b), .busy(busy_b), .done(done_b), .err(err_b),
    .FLAGD(FLAGD), .FIFOADR(fifoadr_b), .SLWR(slwr_b), .SLRD(slrd_b), .SLOE(sloe_b),
    .pktend(pktend_b), .fdata_out(fdata_b), .fdata_oe(oe_b), .data_o(data_o), .stall_o(stall_o),
    .sdram_ack(sdram_ack), .stb_i(stb_b), .cyc_i(cyc_b), .we_i(we_b), .sel_i(sel_b), .addr_i(addr_b));

  logic m_busy, m_done, m_err, m_slwr, m_pktend, m_oe, m_stb, m_cyc;
  logic [15:0] m_fdata;
  logic [3:0]  m_sel;
  logic [31:0] m_addr;
  assign m_busy   = use_b ? busy_b   : busy_a;
  assign m_done   = use_b ? done_b   : done_a;
  assign m_err    = use_b ? err_b    : err_a;
  assign m_slwr   = use_b ? slwr_b   : slwr_a;
  assign m_pktend = use_b ? pktend_b : pktend_a;
  assign m_oe     = use_b ? oe_b     : oe_a;
  assign m_stb    = use_b ? stb_b    : stb_a;
  assign m_cyc    = use_b ? cyc_b    : cyc_a;
  assign m_fdata  = use_b ? fdata_b  : fdata_a;
  assign m_sel    = use_b ? sel_b    : sel_a;
  assign m_addr   = use_b ? addr_b   : addr_a;

  always #5 CLK = ~CLK;

  int cycnt = 0;
  always @(posedge CLK) cycnt <= cycnt + 1;

  int n_chk = 0;
  int n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Run configuration (written by the main sequence) and per-run results (written by env).
  int run_id = 0;
  int stall_w = -1, flag_w = -1;
  bit fast = 1'b0, noack = 1'b0;
  logic [31:0] exp_base = BASE_A;
  int writes = 0, pktends = 0, dones = 0, done_at = 0, sb_left = 0, cyc_hi = 0, accepts = 0;
  logic [15:0] sb_q[$];

  // SDRAM slave, FX2 FIFO model and output monitor, all acting on the falling edge.
  initial begin : env
    int seen, stall_left, hold_left;
    bit armed, chk_wr, pend;
    logic [31:0] pend_addr, ea;
    seen = 0; stall_left = 0; hold_left = 0; armed = 1'b0; chk_wr = 1'b0; pend = 1'b0;
    pend_addr = '0;
    FLAGD = 1'b1; stall_o = 1'b0; sdram_ack = 1'b0; data_o = '0;
    forever begin
      @(negedge CLK);
      if (!rst_n) begin
        pend = 1'b0; sdram_ack = 1'b0; stall_o = 1'b0; FLAGD = 1'b1;
        hold_left = 0; chk_wr = 1'b0; sb_q.delete();
      end else begin
        if (run_id != seen) begin
          seen = run_id; accepts = 0; stall_left = 5; armed = 1'b1;
          writes = 0; pktends = 0; dones = 0; cyc_hi = 0; sb_left = 0; sb_q.delete();
        end
        if (m_cyc) cyc_hi++;
        if (m_done) begin
          dones++; done_at = cycnt; sb_left = sb_q.size(); sb_q.delete();
        end
        if (!m_pktend) pktends++;
        if (chk_wr) begin
          check("wr_after_flagd", 32'(m_slwr), 32'd0);
          chk_wr = 1'b0;
        end
        if (!m_slwr) begin
          writes++;
          check("wr_oe", 32'(m_oe), 32'd1);
          if (sb_q.size() == 0) check("wr_unexpected", {16'h0, m_fdata}, 32'hFFFF_FFFF);
          else check("wr_data", 32'(m_fdata), 32'(sb_q.pop_front()));
        end
        // FIFO-full window: write must be held off with data stable
        if (hold_left > 0) begin
          check("hold_slwr", 32'(m_slwr), 32'd1);
          if (sb_q.size() > 0) check("hold_data", 32'(m_fdata), 32'(sb_q[0]));
          hold_left--;
          if (hold_left == 0) begin FLAGD = 1'b1; chk_wr = 1'b1; end
        end else if (armed && writes == flag_w && m_oe && m_slwr) begin
          FLAGD = 1'b0; hold_left = 10; armed = 1'b0;
        end
        sdram_ack = 1'b0;
        stall_o   = 1'b0;
        if (pend) begin
          sdram_ack = 1'b1;
          data_o = {16'hDEAD, 16'hA000 + pend_addr[15:0]};
          pend = 1'b0;
        end
        if (m_cyc && m_stb) begin
          ea = exp_base + 32'(accepts);
          if (accepts == stall_w && stall_left > 0) begin
            stall_o = 1'b1; stall_left--;
            check("stall_addr", m_addr, ea);
          end else begin
            check("rd_addr", m_addr, ea);
            check("rd_sel", 32'(m_sel), 32'h3);
            sb_q.push_back(16'hA000 + ea[15:0]);
            accepts++;
            if (fast) begin
              sdram_ack = 1'b1;
              data_o = {16'hDEAD, 16'hA000 + m_addr[15:0]};
            end else if (!noack) begin
              pend = 1'b1; pend_addr = m_addr;
            end
          end
        end
      end
    end
  end

  task automatic chk_reset();
    check("rst_busy",   32'(m_busy),   32'd0);
    check("rst_done",   32'(m_done),   32'd0);
    check("rst_err",    32'(m_err),    32'd0);
    check("rst_slwr",   32'(m_slwr),   32'd1);
    check("rst_pktend", 32'(m_pktend), 32'd1);
    check("rst_oe",     32'(m_oe),     32'd0);
    check("rst_fdata",  32'(m_fdata),  32'd0);
    check("rst_stb",    32'(m_stb),    32'd0);
    check("rst_cyc",    32'(m_cyc),    32'd0);
    check("rst_sel",    32'(m_sel),    32'd0);
    check("rst_addr_a", addr_a, BASE_A);
    check("rst_addr_b", addr_b, BASE_B);
    check("rst_cyc_b",  32'(cyc_b), 32'd0);
    check("rst_consts_a", {26'd0, fifoadr_a, slrd_a, sloe_a, we_a, 1'b0}, {26'd0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0});
    check("rst_consts_b", {26'd0, fifoadr_b, slrd_b, sloe_b, we_b, 1'b0}, {26'd0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic run(input bit b, input int sw, input int fw, input bit f, input bit na, input bit dbl,
                     input int exp_lat, input int exp_wr, input int exp_pe, input logic exp_err,
                     input int exp_sb);
    int t0;
    use_b = b; stall_w = sw; flag_w = fw; fast = f; noack = na;
    exp_base = b ? BASE_B : BASE_A;
    run_id++;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0; t0 = cycnt;
    check("busy_after_start", 32'(m_busy), 32'd1);
    if (dbl) begin
      repeat (4) @(negedge CLK);
      start = 1'b1;
      @(negedge CLK); start = 1'b0;
    end
    for (int i = 0; i < 1000 && dones == 0; i++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    check("done_count", 32'(dones), 32'd1);
    check("done_latency", 32'(done_at - t0), 32'(exp_lat));
    check("slwr_pulses", 32'(writes), 32'(exp_wr));
    check("pktend_pulses", 32'(pktends), 32'(exp_pe));
    check("sb_left", 32'(sb_left), 32'(exp_sb));
    check("busy_end", 32'(m_busy), 32'd0);
    check("err_end", 32'(m_err), 32'(exp_err));
  endtask

  initial begin : main
    rst_n = 1'b0; start = 1'b0; use_b = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge CLK);

    run(1'b0, -1, -1, 1'b0, 1'b0, 1'b0, 18, 4, 1, 1'b0, 0);  // short packet, pktend
    run(1'b1, -1, -1, 1'b0, 1'b0, 1'b0, 33, 8, 0, 1'b0, 0);  // exact packets, addr wrap
    run(1'b1, -1, -1, 1'b1, 1'b0, 1'b0, 25, 8, 0, 1'b0, 0);  // ack with strobe
    run(1'b0,  2, -1, 1'b0, 1'b0, 1'b0, 23, 4, 1, 1'b0, 0);  // 5-cycle stall on word 2
    run(1'b0, -1,  1, 1'b0, 1'b0, 1'b0, 28, 4, 1, 1'b0, 0);  // FIFO full before word 1
    run(1'b0, -1, -1, 1'b0, 1'b0, 1'b1, 18, 4, 1, 1'b0, 0);  // start while busy

    // Asynchronous reset while waiting for an ack, then a clean transfer.
    use_b = 1'b0; stall_w = -1; flag_w = -1; fast = 1'b0; noack = 1'b0; exp_base = BASE_A;
    run_id++;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    for (int i = 0; i < 100 && !(m_cyc && !m_stb && accepts == 3); i++) @(negedge CLK);
    check("rst_rdwait_seen", 32'(m_cyc && !m_stb), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK);
    run(1'b0, -1, -1, 1'b0, 1'b0, 1'b0, 18, 4, 1, 1'b0, 0);

`ifdef WRITE_TO_USB_ACK_TIMEOUT_EN
    run(1'b0, -1, -1, 1'b0, 1'b1, 1'b0, 255, 0, 0, 1'b1, 1);
    check("tmo_cyc_high", 32'(cyc_hi), 32'd255);
    run(1'b0, -1, -1, 1'b0, 1'b0, 1'b0, 18, 4, 1, 1'b0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
